// File: rtl/cfgreg_boot_seq_if.sv
// cfgreg_boot_seq_if: APB write-only port between the boot sequencer and the cfgreg block.
interface cfgreg_boot_seq_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic        pready;
  logic        pslverr;
  modport master(output psel, penable, pwrite, paddr, pwdata, input pready, pslverr);
  modport slave(input psel, penable, pwrite, paddr, pwdata, output pready, pslverr);
endinterface

// File: rtl/cfgreg_boot_seq.sv
// cfgreg_boot_seq: APB master that boots the core (BOOTVEC, DDROFFSET, RSTN=1)
// and later serves core re-reset requests (RSTN=0, hold, RSTN=1).
module cfgreg_boot_seq #(
  parameter bit          AUTO_BOOT    = 1'b1,
  parameter int          HOLD_CYC     = 16,
  parameter int          TIMEOUT      = 64,
  parameter logic [11:0] BOOTVEC_ADDR = 12'h000,
  parameter logic [11:0] DDROFF_ADDR  = 12'h004,
  parameter logic [11:0] RSTN_ADDR    = 12'h008
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               boot_start_i,
  input  logic [31:0]        boot_addr_i,
  input  logic [31:0]        ddr_off_i,
  input  logic               rst_req_i,
  cfgreg_boot_seq_if.master  apb,
  output logic               busy_o,
  output logic               boot_done_o,
  output logic               seq_err_o
);
  localparam logic [2:0] IDLE = 3'd0, SETUP = 3'd1, ACCESS = 3'd2, HOLD = 3'd3, DONE = 3'd4;
  localparam int CW = $clog2((HOLD_CYC > TIMEOUT ? HOLD_CYC : TIMEOUT) + 1);
  logic [2:0]    state_q, state_d;
  logic [1:0]    step_q, step_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d, load, xfer_end;
  logic          pwrite_q;
  logic [11:0]   paddr_q;
  logic [31:0]   pwdata_q, ddr_q;
  // Steps: 0 BOOTVEC, 1 DDROFFSET, 2 RSTN<-1, 3 RSTN<-0 (re-reset, followed by HOLD then step 2)
  assign xfer_end = apb.pready || cnt_q == CW'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    load    = 1'b0;
    case (state_q)
      IDLE: if (AUTO_BOOT || boot_start_i) begin
        state_d = SETUP;
        step_d  = 2'd0;
        load    = 1'b1;
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: if (xfer_end) begin
        err_d   = err_q | ~apb.pready | apb.pslverr;
        cnt_d   = '0;
        state_d = step_q == 2'd2 ? DONE : step_q == 2'd3 ? HOLD : SETUP;
        step_d  = step_q[1] ? 2'd2 : step_q + 2'd1;
        load    = ~step_q[1];
      end else cnt_d = cnt_q + CW'(1);
      HOLD: if (cnt_q == CW'(HOLD_CYC - 1)) begin
        state_d = SETUP;
        load    = 1'b1;
      end else cnt_d = cnt_q + CW'(1);
      DONE: if (rst_req_i) begin
        state_d = SETUP;
        step_d  = 2'd3;
        load    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      step_q   <= 2'd0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      ddr_q    <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (state_q == IDLE) ddr_q <= ddr_off_i;
      if (load) begin
        pwrite_q <= 1'b1;
        paddr_q  <= step_d == 2'd0 ? BOOTVEC_ADDR : step_d == 2'd1 ? DDROFF_ADDR : RSTN_ADDR;
        pwdata_q <= step_d == 2'd0 ? boot_addr_i : step_d == 2'd1 ? ddr_q : {31'd0, step_d == 2'd2};
      end
    end
  end
  assign apb.psel    = state_q == SETUP || state_q == ACCESS;
  assign apb.penable = state_q == ACCESS;
  assign apb.pwrite  = pwrite_q;
  assign apb.paddr   = paddr_q;
  assign apb.pwdata  = pwdata_q;
  assign busy_o      = apb.psel || state_q == HOLD;
  assign boot_done_o = state_q == DONE;
  assign seq_err_o   = err_q;
endmodule

// File: tb/tb_cfgreg_boot_seq.sv
// tb_cfgreg_boot_seq: randomized boot/re-reset scenarios against a cycle-arithmetic model
// of the write schedule; dut_a auto-boots, dut_b waits for boot_start.
module tb_cfgreg_boot_seq;
  localparam logic [11:0] BV = 12'h000, DD = 12'h004, RS = 12'h008;
  localparam int TO = 4, HC = 16;
  typedef struct { int c; logic [11:0] a; logic [31:0] d; } wr_t;
  logic clk = 0, rstn = 0, boot_start = 0, rst_req = 0;
  logic [31:0] boot_addr = 0, ddr_off = 0;
  logic busy_a, done_a, err_a, busy_b, done_b, err_b;
  int nchk = 0, nerr = 0, cyc = 0;
  wr_t wr_a[$], wr_b[$];
  int wq[$];
  bit eq[$];
  int cur_w = 0, acc = 0;
  bit cur_e = 0;
  logic [11:0] s_addr;
  logic [31:0] s_data;
  cfgreg_boot_seq_if ia();
  cfgreg_boot_seq_if ib();
  cfgreg_boot_seq #(.AUTO_BOOT(1'b1), .HOLD_CYC(HC), .TIMEOUT(TO), .BOOTVEC_ADDR(BV), .DDROFF_ADDR(DD), .RSTN_ADDR(RS)) dut_a (
    .clk(clk), .rstn(rstn), .boot_start_i(1'b0), .boot_addr_i(boot_addr), .ddr_off_i(ddr_off),
    .rst_req_i(rst_req), .apb(ia), .busy_o(busy_a), .boot_done_o(done_a), .seq_err_o(err_a));
  cfgreg_boot_seq #(.AUTO_BOOT(1'b0), .HOLD_CYC(HC), .TIMEOUT(TO), .BOOTVEC_ADDR(BV), .DDROFF_ADDR(DD), .RSTN_ADDR(RS)) dut_b (
    .clk(clk), .rstn(rstn), .boot_start_i(boot_start), .boot_addr_i(boot_addr), .ddr_off_i(ddr_off),
    .rst_req_i(1'b0), .apb(ib), .busy_o(busy_b), .boot_done_o(done_b), .seq_err_o(err_b));
  assign ib.pready  = 1'b1;
  assign ib.pslverr = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else cyc <= cyc + 1;
  end
  // Slave model for dut_a: per-transfer wait states and error flag come from wq/eq
  always @(negedge clk) begin
    if (ia.psel && !ia.penable) begin
      wr_a.push_back('{cyc, ia.paddr, ia.pwdata});
      cur_w = 0;
      cur_e = 0;
      if (wq.size() > 0) cur_w = wq.pop_front();
      if (eq.size() > 0) cur_e = eq.pop_front();
      acc = 0;
      s_addr = ia.paddr;
      s_data = ia.pwdata;
      ia.pready = 0;
      ia.pslverr = 0;
      nchk++;
      if (ia.pwrite !== 1'b1) begin nerr++; $display("FAIL pwrite_setup: got %b want 1", ia.pwrite); end
    end else if (ia.psel && ia.penable) begin
      nchk++;
      if (ia.paddr !== s_addr || ia.pwdata !== s_data || ia.pwrite !== 1'b1) begin
        nerr++;
        $display("FAIL access_stable: got %h/%h/%b want %h/%h/1", ia.paddr, ia.pwdata, ia.pwrite, s_addr, s_data);
      end
      ia.pready = acc >= cur_w;
      ia.pslverr = ia.pready && cur_e;
      acc++;
    end else begin
      ia.pready = 0;
      ia.pslverr = 0;
    end
    if (ib.psel && !ib.penable) wr_b.push_back('{cyc, ib.paddr, ib.pwdata});
  end
  task automatic start_boot(input int w[3], input bit e[3], input logic [31:0] ba, input logic [31:0] dof);
    rstn = 0;
    boot_addr = ba;
    ddr_off = dof;
    repeat (2) @(negedge clk);
    wq.delete(); eq.delete(); wr_a.delete(); wr_b.delete();
    for (int i = 0; i < 3; i++) begin wq.push_back(w[i]); eq.push_back(e[i]); end
    rstn = 1;
  endtask
  task automatic run_boot(input string nm, input int w[3], input bit e[3], input logic [31:0] ba, input logic [31:0] dof);
    int t, dc;
    int ec[3];
    logic [11:0] ea[3];
    logic [31:0] ed[3];
    bit ee;
    t = 1;
    ee = 0;
    ea = '{BV, DD, RS};
    ed = '{ba, dof, 32'h1};
    for (int i = 0; i < 3; i++) begin
      ec[i] = t;
      t += 1 + (w[i] >= TO ? TO : w[i] + 1);
      ee |= (w[i] >= TO) | e[i];
    end
    start_boot(w, e, ba, dof);
    dc = -1;
    for (int k = 0; k < 200 && dc < 0; k++) begin
      @(negedge clk);
      if (done_a) dc = cyc;
    end
    nchk++;
    if (dc != t) begin nerr++; $display("FAIL %s done_cycle: got %0d want %0d", nm, dc, t); end
    nchk++;
    if (wr_a.size() != 3) begin nerr++; $display("FAIL %s write_count: got %0d want 3", nm, wr_a.size()); end
    else for (int i = 0; i < 3; i++) begin
      nchk++;
      if (wr_a[i].c != ec[i] || wr_a[i].a !== ea[i] || wr_a[i].d !== ed[i]) begin
        nerr++;
        $display("FAIL %s write%0d: got c%0d %h<-%h want c%0d %h<-%h", nm, i, wr_a[i].c, wr_a[i].a, wr_a[i].d, ec[i], ea[i], ed[i]);
      end
    end
    nchk++;
    if (err_a !== ee) begin nerr++; $display("FAIL %s seq_err: got %b want %b", nm, err_a, ee); end
  endtask
  task automatic test_reset;
    rstn = 0;
    repeat (2) @(negedge clk);
    nchk++;
    if ({ia.psel, ia.penable, ia.pwrite, ia.paddr, ia.pwdata} !== '0) begin
      nerr++; $display("FAIL reset_bus_a: got %b%b%b %h %h want all 0", ia.psel, ia.penable, ia.pwrite, ia.paddr, ia.pwdata);
    end
    nchk++;
    if ({busy_a, done_a, err_a, busy_b, done_b, err_b} !== 6'b0) begin
      nerr++; $display("FAIL reset_status: got %b want 000000", {busy_a, done_a, err_a, busy_b, done_b, err_b});
    end
    nchk++;
    if ({ib.psel, ib.penable, ib.pwrite, ib.paddr, ib.pwdata} !== '0) begin
      nerr++; $display("FAIL reset_bus_b: got %b%b%b %h %h want all 0", ib.psel, ib.penable, ib.pwrite, ib.paddr, ib.pwdata);
    end
  endtask
  task automatic test_back_to_back;
    run_boot("basic", '{0, 0, 0}, '{0, 0, 0}, 32'h8000_0000, 32'h3000_0000);
  endtask
  task automatic test_wait_states;
    run_boot("wait3", '{0, 3, 0}, '{0, 0, 0}, 32'h8000_1000, 32'h3000_2000);
    run_boot("slverr", '{1, 0, 2}, '{0, 1, 0}, 32'hdead_beef, 32'h0bad_f00d);
  endtask
  task automatic test_timeout;
    run_boot("timeout", '{9, 9, 9}, '{0, 0, 0}, 32'h1111_2222, 32'h3333_4444);
  endtask
  task automatic test_random;
    int w[3];
    bit e[3];
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 3; i++) begin
        w[i] = $urandom_range(0, 5);
        e[i] = $urandom_range(0, 3) == 0;
      end
      run_boot($sformatf("rand%0d", n), w, e, $urandom, $urandom);
    end
  endtask
  task automatic test_rereset;
    int c, dc, n0, lowbusy;
    run_boot("rr_boot", '{0, 0, 0}, '{0, 0, 0}, 32'h1234_5678, 32'h9abc_def0);
    n0 = wr_a.size();
    c = cyc;
    rst_req = 1;
    dc = -1;
    lowbusy = 0;
    for (int k = 0; k < 100 && dc < 0; k++) begin
      @(negedge clk);
      rst_req = cyc == c + 6;
      if (done_a) dc = cyc;
      else if (!busy_a) lowbusy++;
    end
    rst_req = 0;
    nchk++;
    if (dc != c + 5 + HC) begin nerr++; $display("FAIL rr_done_cycle: got %0d want %0d", dc, c + 5 + HC); end
    nchk++;
    if (lowbusy != 0) begin nerr++; $display("FAIL rr_busy: got %0d idle cycles want 0", lowbusy); end
    repeat (25) @(negedge clk);
    nchk++;
    if (wr_a.size() != n0 + 2) begin nerr++; $display("FAIL rr_write_count: got %0d want %0d", wr_a.size(), n0 + 2); end
    else begin
      nchk++;
      if (wr_a[n0].c != c + 1 || wr_a[n0].a !== RS || wr_a[n0].d !== 32'h0) begin
        nerr++; $display("FAIL rr_rstn0: got c%0d %h<-%h want c%0d %h<-0", wr_a[n0].c, wr_a[n0].a, wr_a[n0].d, c + 1, RS);
      end
      nchk++;
      if (wr_a[n0+1].c != c + 3 + HC || wr_a[n0+1].a !== RS || wr_a[n0+1].d !== 32'h1) begin
        nerr++; $display("FAIL rr_rstn1: got c%0d %h<-%h want c%0d %h<-1", wr_a[n0+1].c, wr_a[n0+1].a, wr_a[n0+1].d, c + 3 + HC, RS);
      end
    end
    nchk++;
    if (done_a !== 1'b1) begin nerr++; $display("FAIL rr_done_after: got %b want 1", done_a); end
  endtask
  task automatic test_manual_start;
    int c, dc;
    start_boot('{0, 0, 0}, '{0, 0, 0}, 32'hcafe_0000, 32'h0000_beef);
    repeat (10) @(negedge clk);
    nchk++;
    if (wr_b.size() != 0 || busy_b !== 1'b0 || done_b !== 1'b0) begin
      nerr++; $display("FAIL ms_idle: got writes=%0d busy=%b done=%b want 0/0/0", wr_b.size(), busy_b, done_b);
    end
    c = cyc;
    boot_start = 1;
    dc = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      boot_start = cyc == c + 3 || cyc == c + 12;
      if (done_b && dc < 0) dc = cyc;
    end
    boot_start = 0;
    nchk++;
    if (dc != c + 7) begin nerr++; $display("FAIL ms_done_cycle: got %0d want %0d", dc, c + 7); end
    nchk++;
    if (wr_b.size() != 3) begin nerr++; $display("FAIL ms_write_count: got %0d want 3", wr_b.size()); end
    else begin
      nchk++;
      if (wr_b[0].c != c + 1 || wr_b[0].a !== BV || wr_b[0].d !== 32'hcafe_0000) begin
        nerr++; $display("FAIL ms_bootvec: got c%0d %h<-%h want c%0d %h<-cafe0000", wr_b[0].c, wr_b[0].a, wr_b[0].d, c + 1, BV);
      end
      nchk++;
      if (wr_b[1].c != c + 3 || wr_b[1].a !== DD || wr_b[1].d !== 32'h0000_beef) begin
        nerr++; $display("FAIL ms_ddroff: got c%0d %h<-%h want c%0d %h<-0000beef", wr_b[1].c, wr_b[1].a, wr_b[1].d, c + 3, DD);
      end
      nchk++;
      if (wr_b[2].c != c + 5 || wr_b[2].a !== RS || wr_b[2].d !== 32'h1) begin
        nerr++; $display("FAIL ms_rstn: got c%0d %h<-%h want c%0d %h<-1", wr_b[2].c, wr_b[2].a, wr_b[2].d, c + 5, RS);
      end
    end
    nchk++;
    if (err_b !== 1'b0) begin nerr++; $display("FAIL ms_seq_err: got %b want 0", err_b); end
  endtask
  task automatic test_mid_reset;
    start_boot('{0, 20, 0}, '{0, 0, 0}, 32'h5555_aaaa, 32'haaaa_5555);
    for (int k = 0; k < 20 && cyc != 5; k++) @(negedge clk);
    nchk++;
    if (ia.penable !== 1'b1 || ia.paddr !== DD) begin
      nerr++; $display("FAIL mr_in_access: got penable=%b paddr=%h want 1/%h", ia.penable, ia.paddr, DD);
    end
    rstn = 0;
    #1;
    nchk++;
    if ({ia.psel, ia.penable, ia.pwrite, ia.paddr, ia.pwdata, busy_a, done_a, err_a} !== '0) begin
      nerr++; $display("FAIL mr_async_reset: got %b%b%b %h %h %b%b%b want all 0", ia.psel, ia.penable, ia.pwrite, ia.paddr, ia.pwdata, busy_a, done_a, err_a);
    end
    run_boot("restart", '{0, 0, 0}, '{0, 0, 0}, 32'h5555_aaaa, 32'haaaa_5555);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_back_to_back();
    test_wait_states();
    test_timeout();
    test_rereset();
    test_manual_start();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
